// File: rtl/fetch_sequencer.sv
// Multi-cycle core front end: owns the PC and the global phase counter,
// fetches over a req/valid handshake and holds the instruction word for decode.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_valid,
  input  logic        mem_op,
  input  logic        dmem_done,
  input  logic        pc_redirect,
  input  logic [31:0] pc_target,
  input  logic        halt_req,
  output logic [2:0]  state,
  output logic [31:0] pc,
  output logic [31:0] instr_raw,
  output logic [31:0] instret,
  output logic        halted,
  output logic        misalign_err
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WRITE  = 3'd4,
    HALT   = 3'd5
  } phase_t;

  phase_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instret_q, instret_d;
  logic [31:0] target_q, target_d;
  logic        redir_q, redir_d;
  logic        halted_q, halted_d;
  logic        mis_q, mis_d;

  logic [31:0] next_pc;
  logic        bad_target;

  // Commit address and alignment fault are resolved from the EXEC capture.
  assign next_pc    = redir_q ? target_q : pc_q + 32'd4;
  assign bad_target = redir_q && (target_q[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FETCH;
      pc_q      <= RESET_PC;
      instr_q   <= NOP_INSTR;
      instret_q <= 32'd0;
      target_q  <= 32'd0;
      redir_q   <= 1'b0;
      halted_q  <= 1'b0;
      mis_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      instret_q <= instret_d;
      target_q  <= target_d;
      redir_q   <= redir_d;
      halted_q  <= halted_d;
      mis_q     <= mis_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    instret_d = instret_q;
    target_d  = target_q;
    redir_d   = redir_q;
    halted_d  = halted_q;
    mis_d     = mis_q;
    case (state_q)
      FETCH: begin
        if (imem_valid) begin
          instr_d = imem_rdata;
          state_d = DECODE;
        end
      end
      DECODE: state_d = EXEC;
      EXEC: begin
        redir_d  = pc_redirect;
        target_d = pc_target;
        state_d  = MEM;
      end
      MEM: begin
        if (!mem_op || dmem_done) state_d = WRITE;
      end
      WRITE: begin
        if (bad_target) begin
          mis_d    = 1'b1;
          halted_d = 1'b1;
          state_d  = HALT;
        end else begin
          pc_d      = next_pc;
          instret_d = instret_q + 32'd1;
          redir_d   = 1'b0;
          if (halt_req) begin
            halted_d = 1'b1;
            state_d  = HALT;
          end else begin
            state_d = FETCH;
          end
        end
      end
      HALT: state_d = HALT;
      default: state_d = FETCH;
    endcase
  end

  assign imem_req     = (state_q == FETCH);
  assign imem_addr    = pc_q;
  assign state        = state_q;
  assign pc           = pc_q;
  assign instr_raw    = instr_q;
  assign instret      = instret_q;
  assign halted       = halted_q;
  assign misalign_err = mis_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: phase-rule model checked every cycle
// plus literal expectations at each scenario boundary.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_valid;
  logic        mem_op;
  logic        dmem_done;
  logic        pc_redirect;
  logic [31:0] pc_target;
  logic        halt_req;
  logic [2:0]  state;
  logic [31:0] pc;
  logic [31:0] instr_raw;
  logic [31:0] instret;
  logic        halted;
  logic        misalign_err;

  int vectors = 0;
  int errors  = 0;

  fetch_sequencer dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_valid(imem_valid), .mem_op(mem_op),
    .dmem_done(dmem_done), .pc_redirect(pc_redirect), .pc_target(pc_target),
    .halt_req(halt_req), .state(state), .pc(pc), .instr_raw(instr_raw),
    .instret(instret), .halted(halted), .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks the phase the core should be in and the
  // architectural values implied by the phase rules.
  int          m_ph;
  logic [31:0] m_pc, m_instr, m_instret, m_tgt;
  bit          m_redir, m_halted, m_mis, m_ok = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_ph = 0; m_pc = 32'h0; m_instr = 32'h13; m_instret = 0;
      m_redir = 0; m_tgt = 0; m_halted = 0; m_mis = 0; m_ok = 1;
    end else if (m_ok) begin
      if (m_ph == 0) begin
        if (imem_valid) begin m_instr = imem_rdata; m_ph = 1; end
      end else if (m_ph == 1) m_ph = 2;
      else if (m_ph == 2) begin m_redir = pc_redirect; m_tgt = pc_target; m_ph = 3; end
      else if (m_ph == 3) begin if (!mem_op || dmem_done) m_ph = 4; end
      else if (m_ph == 4) begin
        if (m_redir && (m_tgt % 4 != 0)) begin m_mis = 1; m_halted = 1; m_ph = 5; end
        else begin
          m_pc = m_redir ? m_tgt : m_pc + 32'd4;
          m_instret = m_instret + 1;
          m_redir = 0;
          if (halt_req) begin m_halted = 1; m_ph = 5; end else m_ph = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_ok && !rst) begin
      chk("m_state", {29'd0, state}, m_ph[31:0]);
      chk("m_pc", pc, m_pc);
      chk("m_imem_addr", imem_addr, m_pc);
      chk("m_imem_req", {31'd0, imem_req}, {31'd0, (m_ph == 0)});
      chk("m_instr_raw", instr_raw, m_instr);
      chk("m_instret", instret, m_instret);
      chk("m_halted", {31'd0, halted}, {31'd0, m_halted});
      chk("m_misalign", {31'd0, misalign_err}, {31'd0, m_mis});
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    imem_valid = 0; imem_rdata = 32'hDEAD_BEEF; mem_op = 0; dmem_done = 0;
    pc_redirect = 0; pc_target = 32'h0BAD_F00D; halt_req = 0;
  endtask

  task automatic do_reset();
    rst = 1; step(); rst = 0;
    chk("rst_state", {29'd0, state}, 32'd0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_instr", instr_raw, 32'h13);
    chk("rst_instret", instret, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_mis", {31'd0, misalign_err}, 32'd0);
    chk("rst_req", {31'd0, imem_req}, 32'd1);
  endtask

  // One instruction, driven by cycle count: fw idle FETCH cycles, mw wait
  // cycles in MEM before dmem_done when mop=1.
  task automatic run_instr(input logic [31:0] word, input int fw, input bit mop,
                           input int mw, input bit rd, input logic [31:0] tgt,
                           input bit hr);
    logic [31:0] prev;
    prev = instr_raw;
    mem_op = mop;
    dmem_done = 1;  // ignored outside MEM
    for (int i = 0; i < fw; i++) begin
      imem_valid = 0;
      chk("fetch_wait_state", {29'd0, state}, 32'd0);
      chk("fetch_wait_req", {31'd0, imem_req}, 32'd1);
      chk("fetch_wait_instr", instr_raw, prev);
      step();
    end
    dmem_done = 0;
    imem_valid = 1; imem_rdata = word;
    chk("fetch_state", {29'd0, state}, 32'd0);
    chk("fetch_req", {31'd0, imem_req}, 32'd1);
    step();
    imem_rdata = 32'h1111_2222;  // late valid in DECODE must be ignored
    chk("decode_state", {29'd0, state}, 32'd1);
    chk("decode_instr", instr_raw, word);
    step();
    imem_valid = 0; imem_rdata = 32'hDEAD_BEEF;
    pc_redirect = rd; pc_target = tgt; halt_req = 1;  // early halt_req ignored
    chk("exec_state", {29'd0, state}, 32'd2);
    step();
    pc_redirect = 0; pc_target = 32'h0BAD_F00D; halt_req = 0;
    if (mop) begin
      for (int i = 0; i < mw; i++) begin
        chk("mem_wait_state", {29'd0, state}, 32'd3);
        step();
      end
      dmem_done = 1;
    end
    chk("mem_state", {29'd0, state}, 32'd3);
    step();
    dmem_done = 0;
    halt_req = hr;
    chk("write_state", {29'd0, state}, 32'd4);
    chk("write_instr", instr_raw, word);
    step();
    halt_req = 0;
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    step(); step();
    do_reset();

    // zero-wait instruction
    run_instr(32'h0050_0093, 0, 0, 0, 0, 0, 0);
    chk("t1_state", {29'd0, state}, 32'd0);
    chk("t1_pc", pc, 32'h4);
    chk("t1_instret", instret, 32'd1);

    // three idle FETCH cycles
    run_instr(32'h0010_8113, 3, 0, 0, 0, 0, 0);
    chk("t2_pc", pc, 32'h8);
    chk("t2_instret", instret, 32'd2);

    // MEM stretched to 3 cycles
    run_instr(32'h0000_A183, 0, 1, 2, 0, 0, 0);
    chk("t3_state", {29'd0, state}, 32'd0);
    chk("t3_pc", pc, 32'hC);

    // aligned redirect, then sequential
    run_instr(32'h0400_006F, 0, 0, 0, 1, 32'h40, 0);
    chk("t4_pc", pc, 32'h40);
    chk("t4_addr", imem_addr, 32'h40);
    chk("t4_req", {31'd0, imem_req}, 32'd1);
    run_instr(32'h0000_0013, 0, 0, 0, 0, 0, 0);
    chk("t4_seq_pc", pc, 32'h44);
    chk("t4_instret", instret, 32'd5);

    // PC wrap through redirect to the top word
    run_instr(32'h0000_006F, 0, 0, 0, 1, 32'hFFFF_FFFC, 0);
    chk("wrap_pre", pc, 32'hFFFF_FFFC);
    run_instr(32'h0000_0013, 0, 0, 0, 0, 0, 0);
    chk("wrap_pc", pc, 32'h0);
    chk("wrap_instret", instret, 32'd7);

    // misaligned redirect halts without committing
    run_instr(32'h0420_006F, 0, 0, 0, 1, 32'h42, 0);
    chk("mis_state", {29'd0, state}, 32'd5);
    chk("mis_halted", {31'd0, halted}, 32'd1);
    chk("mis_err", {31'd0, misalign_err}, 32'd1);
    chk("mis_pc", pc, 32'h0);
    chk("mis_instret", instret, 32'd7);
    chk("mis_req", {31'd0, imem_req}, 32'd0);
    imem_valid = 1; imem_rdata = 32'h5555_5555;
    for (int i = 0; i < 3; i++) step();
    imem_valid = 0;
    chk("mis_hold_state", {29'd0, state}, 32'd5);
    chk("mis_hold_instr", instr_raw, 32'h0420_006F);

    // reset while stalled in MEM
    do_reset();
    idle_inputs();
    mem_op = 1;
    imem_valid = 1; imem_rdata = 32'h0000_A203; step();
    imem_valid = 0; step(); step();
    chk("mrst_in_mem", {29'd0, state}, 32'd3);
    step();
    chk("mrst_stall", {29'd0, state}, 32'd3);
    rst = 1; step(); rst = 0;
    chk("mrst_state", {29'd0, state}, 32'd0);
    chk("mrst_pc", pc, 32'h0);
    chk("mrst_instr", instr_raw, 32'h13);
    chk("mrst_instret", instret, 32'd0);
    mem_op = 0;

    // halt request at WRITE
    do_reset();
    run_instr(32'h0000_0073, 0, 0, 0, 0, 0, 1);
    chk("halt_state", {29'd0, state}, 32'd5);
    chk("halt_halted", {31'd0, halted}, 32'd1);
    chk("halt_instret", instret, 32'd1);
    chk("halt_pc", pc, 32'h4);
    chk("halt_mis", {31'd0, misalign_err}, 32'd0);
    imem_valid = 1; mem_op = 1; dmem_done = 1; pc_redirect = 1; halt_req = 1;
    for (int i = 0; i < 4; i++) step();
    idle_inputs();
    chk("halt_hold_state", {29'd0, state}, 32'd5);
    chk("halt_hold_instret", instret, 32'd1);
    do_reset();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Upstream neighbour of the decode stage in the multi-cycle core.
- Owns the PC and the global phase counter (FETCH=0, DECODE=1, EXEC=2, MEM=3, WRITE=4, HALT=5) that every stage samples.
- Fetches instructions over a request/valid handshake to instruction memory and presents the latched instruction word to decode.
- Waits on data memory in MEM; commits the next PC in WRITE.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, instr_raw value after reset (addi x0,x0,0).

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  synchronous active-high reset.
- imem_req  output  1  instruction fetch request.
- imem_addr  output  32  fetch address; always equals pc.
- imem_rdata  input  32  fetched instruction word.
- imem_valid  input  1  imem_rdata valid this cycle.
- mem_op  input  1  current instruction accesses data memory (mem_read | mem_write from decode).
- dmem_done  input  1  data access complete this cycle.
- pc_redirect  input  1  from EXEC: take pc_target instead of pc+4.
- pc_target  input  32  redirect target.
- halt_req  input  1  stop after the current instruction commits.
- state  output  3  current phase.
- pc  output  32  address of the instruction in flight.
- instr_raw  output  32  latched instruction word, stable from DECODE through WRITE.
- instret  output  32  retired-instruction counter.
- halted  output  1  core stopped.
- misalign_err  output  1  sticky; set when the redirect target is not word aligned.

Behaviour:
- Reset, synchronous and active-high, on any posedge with rst=1, regardless of phase:
  - state=FETCH, pc=RESET_PC, instr_raw=NOP_INSTR, instret=0, halted=0, misalign_err=0.
  - Any captured redirect is cleared.
  - rst dominates every other input.
- imem_req is combinational: 1 iff state==FETCH. imem_addr = pc at all times.
- FETCH:
  - If imem_valid=1 at the edge: instr_raw <= imem_rdata, state <= DECODE.
  - Otherwise remain in FETCH; there is no timeout.
  - Minimum FETCH occupancy is 1 cycle (response in the same cycle as the request).
  - imem_valid in any other state is ignored.
- DECODE -> EXEC: unconditional, 1 cycle each.
- EXEC -> MEM: unconditional, 1 cycle.
  - pc_redirect and pc_target are sampled only in EXEC and held in internal registers (redir_q, target_q) until WRITE.
- MEM:
  - If mem_op=0: go to WRITE after 1 cycle.
  - If mem_op=1: stay until dmem_done=1 is sampled, then go to WRITE.
  - dmem_done outside MEM is ignored. dmem_done in the same cycle as entry counts, giving a 1-cycle MEM.
- WRITE, 1 cycle:
  - next = redir_q ? target_q : pc+4, 32-bit wrap (32'hFFFF_FFFC + 4 = 0).
  - If redir_q and target_q[1:0]!=0: misalign_err<=1, halted<=1, state<=HALT, pc unchanged, instret unchanged.
  - Otherwise: pc<=next, instret<=instret+1 (wraps at 2^32), redir_q<=0.
    - If halt_req=1: state<=HALT, halted<=1.
    - Else: state<=FETCH.
- halt_req is sampled only in WRITE. Asserting it earlier has no effect until that instruction's WRITE.
- HALT: absorbing state, left only by rst. imem_req=0 and all outputs hold.
- instr_raw changes only on FETCH acceptance, so decode sees a stable word throughout DECODE..WRITE.
- Encodings 6 and 7 of state are never produced. If reached, the next state is FETCH.
- Single-instruction latency: 5 cycles minimum (one per phase, zero-wait memories).

Test Plan:
- Reset then zero-wait imem returning 32'h00500093 at pc 0:
  - state sequence 0,1,2,3,4,0; instr_raw=32'h00500093 from the DECODE cycle on.
  - After WRITE: pc=4, instret=1.
- imem_valid held low 3 cycles in FETCH:
  - imem_req high for 4 cycles, state stays 0, instr_raw unchanged until valid.
  - Then DECODE with the new word.
- mem_op=1, dmem_done asserted on the 3rd MEM cycle: MEM lasts exactly 3 cycles, then WRITE, then FETCH.
- pc_redirect=1, pc_target=32'h40 in EXEC:
  - After WRITE pc=32'h40 and imem_addr=32'h40 in the next FETCH.
  - Next instruction without redirect goes to 32'h44.
- pc_target=32'h42 with redirect: after WRITE, state=5, halted=1, misalign_err=1, pc unchanged, instret unchanged, imem_req=0.
- Two cases, each from a fresh reset:
  - rst asserted during MEM with mem_op=1 and dmem_done=0: next cycle state=0, pc=RESET_PC, instr_raw=32'h00000013, instret=0.
  - halt_req=1 during WRITE: state=5, halted=1, instret incremented, and the core stays halted until rst.
